// File: rtl/dmni_br_svc_rx.sv
// Receive-side BrLite service buffer: in-order FIFO of brlite_svc_t messages
// whose oldest entry is presented combinationally as the head for the DMNI registers.
module dmni_br_svc_rx #(
  parameter int BUFFER_SIZE = 8  // power of two, >= 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rx_i,
  input  logic [71:0]                    data_i,
  output logic                           ack_o,
  input  logic                           pop_i,
  output logic [7:0]                     head_ksvc_o,
  output logic [15:0]                    head_seq_source_o,
  output logic [15:0]                    head_producer_o,
  output logic [31:0]                    head_payload_o,
  output logic                           pending_o,
  output logic                           full_o,
  output logic [$clog2(BUFFER_SIZE):0]   count_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;

  // Field layout matches DMNIPkg::brlite_svc_t.
  typedef struct packed {
    logic [31:0] payload;
    logic [15:0] seq_source;
    logic [15:0] producer;
    logic [7:0]  ksvc;
  } svc_t;

  svc_t             mem [BUFFER_SIZE];
  svc_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Flags come from the registered count, so a same-cycle pop never frees a slot early.
  assign full_o    = (count == CNT_W'(BUFFER_SIZE));
  assign pending_o = (count != '0);
  assign ack_o     = rx_i & ~full_o;
  assign count_o   = count;

  assign do_push = ack_o;
  assign do_pop  = pop_i & pending_o;

  // NOTE: the storage array is deliberately not reset; stale entries are never
  // visible because the head is masked whenever count is zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= svc_t'(data_i);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values, regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: combinational outputs get a default before any conditional update,
  // which keeps the block free of inferred latches.
  always_comb begin
    head = '0;
    if (pending_o) head = mem[rd_ptr];
  end

  assign head_payload_o    = head.payload;
  assign head_seq_source_o = head.seq_source;
  assign head_producer_o   = head.producer;
  assign head_ksvc_o       = head.ksvc;

endmodule
